// File: rtl/mipsfpga_lcd_pkg.sv
// ============================================================================
// Module : mipsfpga_lcd_pkg
// Purpose: Shared types and default constants for the LCD SPI feeder.
//          Holds the feeder FSM state encoding, the FIFO entry layout and
//          a helper that converts a cycle count into a count-down preload.
//          MIPSFPGA_LCD_DELAY_EN selects whether the DELAY state is reachable.
//          The state encoding itself is the same in both builds.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mipsfpga_lcd_pkg;

    localparam int c_DEPTH      = 16;
    localparam int c_CS_SETUP   = 4;
    localparam int c_CS_HOLD    = 4;
    localparam int c_GAP_CYCLES = 2;
    localparam int c_DELAY_UNIT = 25000;

    // Width of the shared SETUP/GAP/HOLD down-counter.
    localparam int c_CNT_W = 16;
    // Width of the delay-command counter (255 * DELAY_UNIT must fit).
    localparam int c_DLY_W = 24;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        LOAD  = 3'd2,
        SEND  = 3'd3,
        WAIT  = 3'd4,
        GAP   = 3'd5,
        HOLD  = 3'd6,
        DELAY = 3'd7
    } state_t;

    // Matches wr_data: [9] delay flag, [8] dc, [7:0] byte.
    typedef struct packed {
        logic       delay;
        logic       dc;
        logic [7:0] data;
    } entry_t;

    localparam int c_ENTRY_W = $bits(entry_t);

    // A state that must last N cycles is preloaded with N-1 and left when the
    // counter reads zero; N=0 degenerates to a single cycle.
    function automatic logic [c_CNT_W-1:0] count_init(input int unsigned cycles);
        return (cycles == 0) ? '0 : c_CNT_W'(cycles - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mipsfpga_lcd_fifo.sv
// ============================================================================
// Module : mipsfpga_lcd_fifo
// Purpose: Single-clock show-ahead FIFO. A push while full is dropped and
//          sets the sticky ovf flag (even if a pop happens the same cycle).
//          flush clears pointers, level and ovf and overrides push and pop.
// Ports  : clk, resetn (async, active-low), flush, push/push_data,
//          pop/pop_data (head, valid while !empty), full, empty, level, ovf
// Params : DEPTH (power of two, 2..256), WIDTH
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mipsfpga_lcd_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         ovf
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_LW-1:0]  r_level;
    logic             r_ovf;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_level == c_LW'(DEPTH));
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign ovf       = r_ovf;
    assign pop_data  = r_mem[r_rd_ptr];

    assign w_push_ok = push && !full && !flush;
    assign w_pop_ok  = pop && !empty && !flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            // DEPTH is a power of two, so pointer wrap is the natural overflow.
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            if (push && full) r_ovf <= 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + c_LW'(1);
                2'b01:   r_level <= r_level - c_LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/mipsfpga_lcd_spi_feeder.sv
// ============================================================================
// Module : mipsfpga_lcd_spi_feeder
// Purpose: Buffers LCD command/data bytes and feeds them one at a time to the
//          SPI byte transmitter through the spi_data/spi_send/spi_done
//          handshake. It also frames the bytes with lcd_cs_n and lcd_dc.
//          Define MIPSFPGA_LCD_DELAY_EN to enable delay commands (entry bit 9):
//          such an entry waits data*DELAY_UNIT cycles instead of transferring.
// Ports  : clk, resetn (async, active-low)
//          wr_en/wr_data, flush      - write side from the register block
//          full, empty, level, ovf   - FIFO status
//          busy                      - FSM not idle
//          spi_data, spi_send, spi_done - transmitter handshake
//          lcd_dc, lcd_cs_n          - LCD framing lines
// Params : DEPTH, CS_SETUP, CS_HOLD, GAP_CYCLES (each >= 1), DELAY_UNIT
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mipsfpga_lcd_spi_feeder
    import mipsfpga_lcd_pkg::*;
#(
    parameter int DEPTH      = c_DEPTH,
    parameter int CS_SETUP   = c_CS_SETUP,
    parameter int CS_HOLD    = c_CS_HOLD,
    parameter int GAP_CYCLES = c_GAP_CYCLES,
    parameter int DELAY_UNIT = c_DELAY_UNIT
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         wr_en,
    input  logic [9:0]                   wr_data,
    input  logic                         flush,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         ovf,
    output logic                         busy,
    output logic [7:0]                   spi_data,
    output logic                         spi_send,
    input  logic                         spi_done,
    output logic                         lcd_dc,
    output logic                         lcd_cs_n
);

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [7:0]           r_spi_data;
    logic                 r_spi_send;
    logic                 r_lcd_dc;
    logic                 r_cs_n;
    logic                 r_done_seen;
    logic [c_ENTRY_W-1:0] w_head_raw;
    entry_t               w_head;
    logic                 w_empty;
    logic                 w_pop;

`ifdef MIPSFPGA_LCD_DELAY_EN
    logic [c_DLY_W-1:0]   r_dly_cnt;
    logic [c_DLY_W-1:0]   w_dly_total;
    assign w_dly_total = c_DLY_W'(w_head.data) * c_DLY_W'(DELAY_UNIT);
`endif

    assign w_head   = entry_t'(w_head_raw);
    assign w_pop    = (r_state == LOAD);
    assign empty    = w_empty;
    assign busy     = (r_state != IDLE);
    assign spi_data = r_spi_data;
    assign spi_send = r_spi_send;
    assign lcd_dc   = r_lcd_dc;
    assign lcd_cs_n = r_cs_n;

    mipsfpga_lcd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (w_pop),
        .pop_data  (w_head_raw),
        .full      (full),
        .empty     (w_empty),
        .level     (level),
        .ovf       (ovf)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_spi_data  <= '0;
            r_spi_send  <= 1'b0;
            r_lcd_dc    <= 1'b0;
            r_cs_n      <= 1'b1;
            r_done_seen <= 1'b0;
`ifdef MIPSFPGA_LCD_DELAY_EN
            r_dly_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_cs_n  <= 1'b0;
                        r_cnt   <= count_init(CS_SETUP);
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    if (r_cnt == '0) r_state <= LOAD;
                    else             r_cnt   <= r_cnt - c_CNT_W'(1);
                end
                LOAD: begin
                    r_done_seen <= 1'b0;
                    // A flush landing just before LOAD leaves nothing to pop.
                    if (w_empty) begin
                        r_cnt   <= count_init(CS_HOLD);
                        r_state <= HOLD;
                    end
`ifdef MIPSFPGA_LCD_DELAY_EN
                    else if (w_head.delay) begin
                        if (w_dly_total == '0) begin
                            r_cnt   <= count_init(GAP_CYCLES);
                            r_state <= GAP;
                        end else begin
                            r_dly_cnt <= w_dly_total - c_DLY_W'(1);
                            r_state   <= DELAY;
                        end
                    end
`endif
                    else begin
                        r_spi_data <= w_head.data;
                        r_lcd_dc   <= w_head.dc;
                        r_spi_send <= 1'b1;
                        r_state    <= SEND;
                    end
                end
                SEND: begin
                    // Only a 1->0 transition of spi_done proves the
                    // transmitter accepted this byte; a low level already
                    // present on entry is ignored until it has gone high.
                    if (spi_done) begin
                        r_done_seen <= 1'b1;
                    end else if (r_done_seen) begin
                        r_spi_send <= 1'b0;
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (spi_done) begin
                        r_cnt   <= count_init(GAP_CYCLES);
                        r_state <= GAP;
                    end
                end
                GAP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end else if (!w_empty) begin
                        r_state <= LOAD;
                    end else begin
                        r_cnt   <= count_init(CS_HOLD);
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (!w_empty) begin
                        r_state <= LOAD;
                    end else if (r_cnt == '0) begin
                        r_cs_n  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
`ifdef MIPSFPGA_LCD_DELAY_EN
                DELAY: begin
                    if (r_dly_cnt == '0) begin
                        r_cnt   <= count_init(GAP_CYCLES);
                        r_state <= GAP;
                    end else begin
                        r_dly_cnt <= r_dly_cnt - c_DLY_W'(1);
                    end
                end
`endif
                default: begin
                    r_spi_send <= 1'b0;
                    r_cs_n     <= 1'b1;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mipsfpga_lcd_spi_feeder.sv
// ============================================================================
// Module : tb_mipsfpga_lcd_spi_feeder
// Purpose: Self-checking bench for mipsfpga_lcd_spi_feeder. A transmitter
//          model answers spi_send; a monitor checks every transfer against a
//          queue of expected bytes and against the framing latencies derived
//          from the parameter values. Delay commands are exercised when
//          MIPSFPGA_LCD_DELAY_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mipsfpga_lcd_spi_feeder;

    localparam int DEPTH      = 16;
    localparam int CS_SETUP   = 4;
    localparam int CS_HOLD    = 4;
    localparam int GAP_CYCLES = 2;
    localparam int DELAY_UNIT = 10;
    localparam int LW         = $clog2(DEPTH + 1);

    // Latencies as seen by negedge sampling:
    // cs_n falls, SETUP lasts CS_SETUP cycles, LOAD one, then spi_send rises.
    localparam int SETUP_LAT = CS_SETUP + 1;
    // spi_done rise -> FSM sees it one edge later -> GAP -> LOAD -> spi_send.
    localparam int BYTE_GAP  = 1 + GAP_CYCLES + 1;
    // spi_done rise -> one edge -> GAP -> HOLD -> cs_n rises.
    localparam int CS_TAIL   = 1 + GAP_CYCLES + CS_HOLD;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          wr_en = 1'b0;
    logic [9:0]    wr_data = '0;
    logic          flush = 1'b0;
    logic          full, empty, ovf, busy, spi_send, lcd_dc, lcd_cs_n;
    logic [LW-1:0] level;
    logic [7:0]    spi_data;
    logic          spi_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mipsfpga_lcd_spi_feeder #(
        .DEPTH      (DEPTH),
        .CS_SETUP   (CS_SETUP),
        .CS_HOLD    (CS_HOLD),
        .GAP_CYCLES (GAP_CYCLES),
        .DELAY_UNIT (DELAY_UNIT)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .flush    (flush),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .ovf      (ovf),
        .busy     (busy),
        .spi_data (spi_data),
        .spi_send (spi_send),
        .spi_done (spi_done),
        .lcd_dc   (lcd_dc),
        .lcd_cs_n (lcd_cs_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Transmitter model: drops spi_done one cycle after seeing spi_send,
    // keeps it low for tx_len cycles, then raises it. tx_stall pins it low.
    logic tx_stall = 1'b0;
    int   tx_len = 20;
    int   tx_cnt;
    logic tx_busy;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            spi_done <= 1'b1;
            tx_busy  <= 1'b0;
            tx_cnt   <= 0;
        end else if (tx_stall) begin
            spi_done <= 1'b0;
        end else if (tx_busy) begin
            if (tx_cnt == 0) begin
                spi_done <= 1'b1;
                tx_busy  <= 1'b0;
            end else begin
                tx_cnt <= tx_cnt - 1;
            end
        end else if (spi_send) begin
            spi_done <= 1'b0;
            tx_busy  <= 1'b1;
            tx_cnt   <= tx_len - 1;
        end
    end

    // Reference model: ordered list of {dc, byte} that must appear on the bus.
    logic [8:0] exp_q[$];
    logic [8:0] cur_exp;
    int   cyc = 0, cs_falls = 0, n_xfer = 0;
    int   t_cs_fall = 0, t_done = 0;
    int   exp_gap = BYTE_GAP;
    logic have_done = 1'b0, in_xfer = 1'b0;
    logic prev_cs = 1'b1, prev_send = 1'b0, prev_done = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (!resetn) begin
            in_xfer   = 1'b0;
            have_done = 1'b0;
        end else begin
            if (!lcd_cs_n && prev_cs) begin
                cs_falls++;
                t_cs_fall = cyc;
                have_done = 1'b0;
            end
            if (spi_send && !prev_send) begin
                n_xfer++;
                chk("cs_low_at_send", {31'd0, lcd_cs_n}, 32'd0);
                chk("xfer_expected", {31'd0, (exp_q.size() > 0)}, 32'd1);
                cur_exp = 9'h000;
                if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
                chk("xfer_data", {23'd0, lcd_dc, spi_data}, {23'd0, cur_exp});
                if (have_done) chk("byte_gap", cyc - t_done, exp_gap);
                else           chk("setup_latency", cyc - t_cs_fall, SETUP_LAT);
                in_xfer = 1'b1;
            end
            if (spi_done && !prev_done && in_xfer) begin
                chk("xfer_held", {23'd0, lcd_dc, spi_data}, {23'd0, cur_exp});
                chk("cs_low_held", {31'd0, lcd_cs_n}, 32'd0);
                t_done    = cyc;
                have_done = 1'b1;
                in_xfer   = 1'b0;
            end
            if (lcd_cs_n && !prev_cs && have_done)
                chk("cs_tail", cyc - t_done, CS_TAIL);
        end
        prev_cs   = lcd_cs_n;
        prev_send = spi_send;
        prev_done = spi_done;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [9:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while ((busy !== 1'b0 || empty !== 1'b1) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, {30'd0, busy, empty}, 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] d;
        int n, k, base_cs, base_x;

        // Reset values
        tick(3);
        chk("rst_flags", {25'd0, full, empty, ovf, busy, spi_send, lcd_dc, lcd_cs_n},
            32'b0100001);
        chk("rst_level", {{(32-LW){1'b0}}, level}, 32'd0);
        chk("rst_data", {24'd0, spi_data}, 32'd0);
        resetn = 1'b1;
        tick(2);

        // Single byte: dc=1, byte 0x2A
        tx_len = 20;
        exp_q.push_back(9'h12A);
        push(10'h12A);
        chk("single_level", {{(32-LW){1'b0}}, level}, 32'd1);
        wait_idle("single_idle");
        chk("single_xfers", n_xfer, 1);
        chk("single_windows", cs_falls, 1);

        // Directed burst: dc sequence 0,1,1 in one CS window
        base_cs = cs_falls;
        base_x  = n_xfer;
        tx_len  = 6;
        exp_q.push_back(9'h036); push(10'h036);
        exp_q.push_back(9'h148); push(10'h148);
        exp_q.push_back(9'h1FF); push(10'h1FF);
        wait_idle("burst_idle");
        chk("burst_windows", cs_falls - base_cs, 1);
        chk("burst_xfers", n_xfer - base_x, 3);

        // Randomised bursts; bit 9 is random where delay commands are absent
        for (int r = 0; r < 6; r++) begin
            n       = $urandom_range(6, 2);
            tx_len  = $urandom_range(20, 2);
            base_cs = cs_falls;
            for (int i = 0; i < n; i++) begin
                d = 10'($urandom);
`ifdef MIPSFPGA_LCD_DELAY_EN
                d[9] = 1'b0;
`endif
                exp_q.push_back(d[8:0]);
                push(d);
            end
            chk("rand_level", {{(32-LW){1'b0}}, level}, n);
            wait_idle("rand_idle");
            chk("rand_windows", cs_falls - base_cs, 1);
            chk("rand_drained", exp_q.size(), 0);
        end

        // Push/pop collision: level 3, write lands on the LOAD cycle
        tx_len = 4;
        for (int i = 0; i < 3; i++) begin
            d = {2'b00, 8'(8'h50 + i)};
            exp_q.push_back(d[8:0]);
            push(d);
        end
        chk("coll_level_pre", {{(32-LW){1'b0}}, level}, 32'd3);
        tick(3);
        exp_q.push_back(9'h1C3);
        push(10'h1C3);
        chk("coll_level_post", {{(32-LW){1'b0}}, level}, 32'd3);
        chk("coll_busy", {31'd0, busy}, 32'd1);
        wait_idle("coll_idle");

        // Overflow with a stalled transmitter, then flush (flush beats write)
        tx_stall = 1'b1;
        tick(2);
        exp_q.push_back(9'h0A5);
        push(10'h0A5);
        tick(8);
        chk("stall_send", {30'd0, spi_send, busy}, 32'd3);
        chk("stall_level", {{(32-LW){1'b0}}, level}, 32'd0);
        for (int i = 0; i < DEPTH; i++) push(10'($urandom));
        chk("ovf_full", {30'd0, full, ovf}, 32'd2);
        chk("ovf_level16", {{(32-LW){1'b0}}, level}, DEPTH);
        push(10'h3FF);
        chk("ovf_sticky", {30'd0, full, ovf}, 32'd3);
        chk("ovf_level", {{(32-LW){1'b0}}, level}, DEPTH);
        flush   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 10'h055;
        @(negedge clk);
        flush   = 1'b0;
        wr_en   = 1'b0;
        chk("flush_flags", {29'd0, full, empty, ovf}, 32'd2);
        chk("flush_level", {{(32-LW){1'b0}}, level}, 32'd0);
        tick(3);
        chk("stall_busy", {31'd0, busy}, 32'd1);
        tx_stall = 1'b0;
        resetn   = 1'b0;
        tick(1);
        exp_q.delete();
        resetn = 1'b1;
        tick(2);

        // Asynchronous reset while waiting for spi_done
        tx_len = 20;
        exp_q.push_back(9'h111); push(10'h111);
        exp_q.push_back(9'h122); push(10'h122);
        k = 0;
        while (spi_send !== 1'b1 && k < 100) begin tick(1); k++; end
        k = 0;
        while (spi_send !== 1'b0 && k < 100) begin tick(1); k++; end
        tick(2);
        chk("in_wait", {29'd0, spi_send, spi_done, busy}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_flags", {28'd0, lcd_cs_n, spi_send, empty, busy}, 32'b1010);
        chk("arst_level", {{(32-LW){1'b0}}, level}, 32'd0);
        exp_q.delete();
        tick(2);
        resetn = 1'b1;
        tick(2);

`ifdef MIPSFPGA_LCD_DELAY_EN
        // Delay command between two bytes: 3 * DELAY_UNIT cycles, CS low
        tx_len  = 5;
        base_cs = cs_falls;
        base_x  = n_xfer;
        exp_gap = BYTE_GAP + 1 + 3 * DELAY_UNIT + GAP_CYCLES;
        exp_q.push_back(9'h011); push(10'h011);
        push(10'h203);
        exp_q.push_back(9'h029); push(10'h029);
        wait_idle("delay_idle");
        chk("delay_windows", cs_falls - base_cs, 1);
        chk("delay_xfers", n_xfer - base_x, 2);
        exp_gap = BYTE_GAP;
`endif

        chk("final_queue", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
